// File: rtl/adder_chains_sched.sv
// adder_chains_sched: round-robin scheduler sharing one pipelined adder_chains
// datapath between NUM_REQ requesters. Each accepted operand vector is tagged
// with its owner id. The owner receives the sum on a one-hot result strobe.
// The scheduler itself contains no adder logic.
//
// Timing: a transfer on edge T registers adder_din and an issue tag on T.
// The chain samples adder_din on edge T+1, and its sum is on adder_dout during
// the cycle after edge T+ADDER_LAT. The tag follows the same path through a
// shift pipe of depth ADDER_LAT. The result is captured on edge T+ADDER_LAT+1.
//
// Optional feature: define ADDER_SCHED_STAT_EN to add the stat_cnt output.
// This output holds one saturating 16-bit transfer counter per requester.
module adder_chains_sched #(
    parameter int MIN_WIDTH = 8,
    parameter int ADDER_NUM = 4,
    parameter int NUM_REQ   = 2,
    parameter int ADDER_LAT = 2,
    localparam int VEC_W    = MIN_WIDTH * ADDER_NUM,
    localparam int SUM_W    = MIN_WIDTH + ADDER_NUM - 1,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*VEC_W-1:0] req_data,
    output logic [VEC_W-1:0]         adder_din,
    input  logic [SUM_W-1:0]         adder_dout,
    output logic [NUM_REQ-1:0]       res_valid,
    output logic [SUM_W-1:0]         res_data
`ifdef ADDER_SCHED_STAT_EN
    ,
    output logic [NUM_REQ*16-1:0]    stat_cnt
`endif
);

    // Decode a requester id into a one-hot requester vector.
    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == id) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W:0]    idx_s;
    logic             grant_any_s;
    logic [ID_W-1:0]  grant_id_s;
    logic             transfer_s;
    logic [VEC_W-1:0] grant_data_s;

    // The issue tag is registered alongside adder_din.
    // The tag pipe then tracks the chain stages.
    logic                 issue_vld_r;
    logic [ID_W-1:0]      issue_id_r;
    logic [ADDER_LAT-1:0] tag_vld_r;
    logic [ID_W-1:0]      tag_id_r [ADDER_LAT];

    // Round-robin search starting at rr_ptr and wrapping modulo NUM_REQ.
    always_comb begin
        grant_any_s = 1'b0;
        grant_id_s  = '0;
        idx_s       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = {1'b0, rr_ptr_r} + (ID_W+1)'(i);
            if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
                idx_s = idx_s - (ID_W+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (!grant_any_s && req_valid[idx_s]) begin
                grant_any_s = 1'b1;
                grant_id_s  = idx_s[ID_W-1:0];
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // Drive the grant. A grant is suppressed while reset is held.
    always_comb begin
        transfer_s   = 1'b0;
        req_ready    = '0;
        grant_data_s = req_data[grant_id_s*VEC_W +: VEC_W];
        if (grant_any_s && !rst) begin
            transfer_s = 1'b1;
            req_ready  = id_onehot(grant_id_s);
        end else begin
            transfer_s = 1'b0;
            req_ready  = '0;
        end
    end

    // Advance the round-robin pointer past the requester that was just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (transfer_s) begin
            if (grant_id_s == ID_W'(NUM_REQ-1)) begin
                rr_ptr_r <= '0;
            end else begin
                rr_ptr_r <= grant_id_s + ID_W'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Register the issued operand vector and its tag.
    // Idle cycles issue zero with an invalid tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            adder_din   <= '0;
            issue_vld_r <= 1'b0;
            issue_id_r  <= '0;
        end else if (transfer_s) begin
            adder_din   <= grant_data_s;
            issue_vld_r <= 1'b1;
            issue_id_r  <= grant_id_s;
        end else begin
            adder_din   <= '0;
            issue_vld_r <= 1'b0;
            issue_id_r  <= '0;
        end
    end

    // The tag shift pipe moves in lockstep with the chain.
    // It never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_r <= '0;
            for (int k = 0; k < ADDER_LAT; k++) begin
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_vld_r[0] <= issue_vld_r;
            tag_id_r[0]  <= issue_id_r;
            for (int k = 1; k < ADDER_LAT; k++) begin
                tag_vld_r[k] <= tag_vld_r[k-1];
                tag_id_r[k]  <= tag_id_r[k-1];
            end
        end
    end

    // Return the chain sum to the owner recorded in the oldest tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= '0;
            res_data  <= '0;
        end else if (tag_vld_r[ADDER_LAT-1]) begin
            res_valid <= id_onehot(tag_id_r[ADDER_LAT-1]);
            res_data  <= adder_dout;
        end else begin
            res_valid <= '0;
            res_data  <= res_data;
        end
    end

`ifdef ADDER_SCHED_STAT_EN
    logic [15:0] stat_r [NUM_REQ];

    // Count transfers per requester. Each counter saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                stat_r[r] <= 16'd0;
            end
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (transfer_s && (grant_id_s == ID_W'(r)) && (stat_r[r] != 16'hFFFF)) begin
                    stat_r[r] <= stat_r[r] + 16'd1;
                end else begin
                    stat_r[r] <= stat_r[r];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_cnt[g*16 +: 16] = stat_r[g];
    end
`endif

endmodule

// File: tb/tb_adder_chains_sched.sv
// Self-checking bench for adder_chains_sched (2 requesters, 4x8-bit, latency 2).
// A behavioural pipelined adder chain is attached. Expected results are pushed
// to a scoreboard at each observed transfer. They are popped when the strobe
// appears, and the bench checks the data, the owner and the exact latency.
module tb_adder_chains_sched;
    localparam int MW    = 8;
    localparam int AN    = 4;
    localparam int NR    = 2;
    localparam int LAT   = 2;
    localparam int VEC_W = MW * AN;
    localparam int SUM_W = MW + AN - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       req_valid;
    logic [NR-1:0]       req_ready;
    logic [NR*VEC_W-1:0] req_data;
    logic [VEC_W-1:0]    adder_din;
    logic [SUM_W-1:0]    adder_dout;
    logic [NR-1:0]       res_valid;
    logic [SUM_W-1:0]    res_data;
`ifdef ADDER_SCHED_STAT_EN
    logic [NR*16-1:0]    stat_cnt;
`endif

    always #5 clk = ~clk;

    adder_chains_sched #(.MIN_WIDTH(MW), .ADDER_NUM(AN), .NUM_REQ(NR), .ADDER_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .adder_din(adder_din), .adder_dout(adder_dout),
        .res_valid(res_valid), .res_data(res_data)
`ifdef ADDER_SCHED_STAT_EN
        , .stat_cnt(stat_cnt)
`endif
    );

    function automatic logic [SUM_W-1:0] vsum(input logic [VEC_W-1:0] v);
        logic [SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < AN; i++) s = s + SUM_W'(v[i*MW +: MW]);
        return s;
    endfunction

    // Behavioural chain: LAT register stages, the first one samples adder_din.
    logic [SUM_W-1:0] chain_pipe [LAT];
    always @(posedge clk) begin
        chain_pipe[0] <= vsum(adder_din);
        for (int k = 1; k < LAT; k++) chain_pipe[k] <= chain_pipe[k-1];
    end
    assign adder_dout = chain_pipe[LAT-1];

    typedef struct {
        logic [NR-1:0]    onehot;
        logic [SUM_W-1:0] sum;
        int               t;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record a transfer, advance one clock, then check outputs on the falling edge.
    task automatic tick();
        exp_t e;
        #1;
        for (int r = 0; r < NR; r++) begin
            if (req_valid[r] && req_ready[r]) begin
                e.onehot = NR'(1) << r;
                e.sum    = vsum(req_data[r*VEC_W +: VEC_W]);
                e.t      = edge_cnt + 1;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        if (res_valid !== '0) begin
            if (sb.size() == 0) begin
                check("unexpected_res", 64'(res_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("res_valid", 64'(res_valid), 64'(e.onehot));
                check("res_data", 64'(res_data), 64'(e.sum));
                check("res_latency", 64'(edge_cnt), 64'(e.t + LAT + 1));
            end
        end else if (sb.size() > 0 && (sb[0].t + LAT + 1) <= edge_cnt) begin
            e = sb.pop_front();
            check("missing_res", 64'(res_valid), 64'(e.onehot));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_ready(input string tag, input logic [NR-1:0] exp);
        #1;
        check(tag, 64'(req_ready), 64'(exp));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b11;
        req_data = {32'h01010101, 32'h01010101};
        // Grant must be suppressed while reset is held.
        check_ready("ready_in_reset", 2'b00);
        ticks(3);
        rst = 1'b0;
        req_valid = 2'b00;
        check("rst_adder_din", 64'(adder_din), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check_ready("idle_ready", 2'b00);

        // 1. Single issue from r0.
        req_data[31:0] = {8'd4, 8'd3, 8'd2, 8'd1};
        req_valid = 2'b01;
        check_ready("t1_grant", 2'b01);
        tick();
        req_valid = 2'b00;
        check_ready("t1_no_grant", 2'b00);
        ticks(4);
        check("t1_res_data_held", 64'(res_data), 64'd10);

        // 2/3. Contention. rr_ptr is 1 after the r0 grant, so r1 wins first.
        req_data = {32'hFFFFFFFF, 32'h01010101};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            check_ready("t2_alternate", (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        req_valid = 2'b00;
        ticks(4);

        // 4. Gaps on r1: valid 1 cycle, idle 2, valid 1. rr_ptr is 1 here.
        req_data[63:32] = 32'h10203040;
        req_valid = 2'b10;
        check_ready("t4_grant_a", 2'b10);
        tick();
        check("t4_din_issue", 64'(adder_din), 64'h10203040);
        req_valid = 2'b00;
        tick();
        check("t4_din_idle1", 64'(adder_din), 64'd0);
        tick();
        check("t4_din_idle2", 64'(adder_din), 64'd0);
        req_data[63:32] = 32'h01020304;
        req_valid = 2'b10;
        check_ready("t4_grant_b", 2'b10);
        tick();
        req_valid = 2'b00;
        ticks(5);

        // 5. Reset one edge after an issue from r0. The issued result must never appear.
        req_data[31:0] = 32'h05050505;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("t5_adder_din", 64'(adder_din), 64'd0);
        check("t5_res_valid", 64'(res_valid), 64'd0);
        check("t5_res_data", 64'(res_data), 64'd0);
        ticks(5);
        req_valid = 2'b11;
        check_ready("t5_lowest_first", 2'b01);
        tick();
        req_valid = 2'b00;
        ticks(5);

`ifdef ADDER_SCHED_STAT_EN
        // 6. Saturating transfer counters.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("t6_stat_reset", 64'(stat_cnt), 64'd0);
        req_valid = 2'b01;
        ticks(5);
        check("t6_stat_five", 64'(stat_cnt), 64'd5);
        ticks(70000 - 5);
        req_valid = 2'b00;
        ticks(5);
        check("t6_stat_r0_sat", 64'(stat_cnt[15:0]), 64'hFFFF);
        check("t6_stat_r1_zero", 64'(stat_cnt[31:16]), 64'd0);
`endif

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
